// File: rtl/mult_share_pkg.sv
// Shared constants and types for the two-requester multiplier-sharing arbiter.
package mult_share_pkg;

  localparam int DATA_W = 32;
  localparam int PROD_W = 2 * DATA_W;

  typedef logic [0:0] tag_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/mult_tag_fifo.sv
// Tag FIFO remembering which requester issued each operation still inside the multiplier.
module mult_tag_fifo
  import mult_share_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  output tag_t head_tag,
  output logic empty,
  output logic full
);

  localparam int AW = $clog2(DEPTH);

  tag_t           mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_tag = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_tag;
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one stream multiplier between two requesters, with tag-ordered return.
module mult_share_arbiter #(
  parameter int DATA_W  = mult_share_pkg::DATA_W,
  parameter int MAX_OUT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s0_a_tdata,
  input  logic [DATA_W-1:0]   s0_b_tdata,
  input  logic                s0_tvalid,
  output logic                s0_tready,
  input  logic [DATA_W-1:0]   s1_a_tdata,
  input  logic [DATA_W-1:0]   s1_b_tdata,
  input  logic                s1_tvalid,
  output logic                s1_tready,
  output logic [2*DATA_W-1:0] m0_tdata,
  output logic                m0_tvalid,
  input  logic                m0_tready,
  output logic [2*DATA_W-1:0] m1_tdata,
  output logic                m1_tvalid,
  input  logic                m1_tready,
  output logic [DATA_W-1:0]   mul_a_tdata,
  output logic                mul_a_tvalid,
  input  logic                mul_a_tready,
  output logic [DATA_W-1:0]   mul_b_tdata,
  output logic                mul_b_tvalid,
  input  logic                mul_b_tready,
  input  logic [2*DATA_W-1:0] mul_p_tdata,
  input  logic                mul_p_tvalid,
  output logic                mul_p_tready,
  output logic                err_orphan
);

  import mult_share_pkg::*;

  localparam int CW = $clog2(MAX_OUT) + 1;

  state_t            state;
  logic [CW-1:0]     count;
  logic              last_served;
  logic              a_done;
  logic              b_done;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;

  logic grant;
  logic room;
  logic accept;
  logic a_hs;
  logic b_hs;
  logic p_hs;
  logic fifo_empty;
  logic fifo_full;
  tag_t head_tag;

  // A tie goes to whichever requester was not served last.
  assign grant     = (s0_tvalid && s1_tvalid) ? ~last_served : s1_tvalid;
  assign room      = rst && (state == IDLE) && (count < CW'(MAX_OUT));
  assign s0_tready = room && !grant;
  assign s1_tready = room && grant;
  assign accept    = (s0_tready && s0_tvalid) || (s1_tready && s1_tvalid);

  assign mul_a_tvalid = (state == ISSUE) && !a_done;
  assign mul_b_tvalid = (state == ISSUE) && !b_done;
  assign mul_a_tdata  = a_reg;
  assign mul_b_tdata  = b_reg;
  assign a_hs         = mul_a_tvalid && mul_a_tready;
  assign b_hs         = mul_b_tvalid && mul_b_tready;

  // With no tag outstanding the product is an orphan and is swallowed.
  assign m0_tvalid    = mul_p_tvalid && !fifo_empty && (head_tag == 1'b0);
  assign m1_tvalid    = mul_p_tvalid && !fifo_empty && (head_tag == 1'b1);
  assign m0_tdata     = mul_p_tdata;
  assign m1_tdata     = mul_p_tdata;
  assign mul_p_tready = rst && (fifo_empty || ((head_tag == 1'b1) ? m1_tready : m0_tready));
  assign p_hs         = mul_p_tvalid && mul_p_tready && !fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      a_done      <= 1'b0;
      b_done      <= 1'b0;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg       <= grant ? s1_a_tdata : s0_a_tdata;
            b_reg       <= grant ? s1_b_tdata : s0_b_tdata;
            a_done      <= 1'b0;
            b_done      <= 1'b0;
            last_served <= grant;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (a_hs) a_done <= 1'b1;
          if (b_hs) b_done <= 1'b1;
          if ((a_done || a_hs) && (b_done || b_hs)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (accept && !p_hs)      count <= count + CW'(1);
      else if (!accept && p_hs) count <= count - CW'(1);
      if (mul_p_tvalid && fifo_empty) err_orphan <= 1'b1;
    end
  end

  mult_tag_fifo #(
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_tag (grant),
    .pop      (p_hs),
    .head_tag (head_tag),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench for mult_share_arbiter against a transaction-level model plus a stand-in multiplier.
module tb_mult_share_arbiter;

  localparam int DW   = 32;
  localparam int MAXO = 4;
  localparam int LAT  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   s0_a_tdata, s0_b_tdata, s1_a_tdata, s1_b_tdata;
  logic            s0_tvalid, s0_tready, s1_tvalid, s1_tready;
  logic [2*DW-1:0] m0_tdata, m1_tdata, mul_p_tdata;
  logic            m0_tvalid, m0_tready, m1_tvalid, m1_tready;
  logic [DW-1:0]   mul_a_tdata, mul_b_tdata;
  logic            mul_a_tvalid, mul_a_tready, mul_b_tvalid, mul_b_tready;
  logic            mul_p_tvalid, mul_p_tready, err_orphan;

  always #5 clk = ~clk;

  mult_share_arbiter #(.DATA_W(DW), .MAX_OUT(MAXO)) dut (
    .clk(clk), .rst(rst),
    .s0_a_tdata(s0_a_tdata), .s0_b_tdata(s0_b_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_a_tdata(s1_a_tdata), .s1_b_tdata(s1_b_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .m0_tdata(m0_tdata), .m0_tvalid(m0_tvalid), .m0_tready(m0_tready),
    .m1_tdata(m1_tdata), .m1_tvalid(m1_tvalid), .m1_tready(m1_tready),
    .mul_a_tdata(mul_a_tdata), .mul_a_tvalid(mul_a_tvalid), .mul_a_tready(mul_a_tready),
    .mul_b_tdata(mul_b_tdata), .mul_b_tvalid(mul_b_tvalid), .mul_b_tready(mul_b_tready),
    .mul_p_tdata(mul_p_tdata), .mul_p_tvalid(mul_p_tvalid), .mul_p_tready(mul_p_tready),
    .err_orphan(err_orphan)
  );

  typedef struct { bit tag; logic [63:0] prod; } exp_t;
  typedef struct { logic [63:0] p; int rdy; } pipe_t;

  int checks = 0;
  int failures = 0;

  // Reference model: one pending issue, outstanding ops in issue order, last winner, sticky error.
  exp_t        exp_q[$];
  bit          m_busy, m_apend, m_bpend, m_last, m_err;
  int          m_count;
  logic [31:0] m_opa, m_opb;

  // Requesters, stand-in multiplier and knobs.
  bit          req_v[2];
  logic [31:0] req_a[2], req_b[2];
  logic [31:0] qa[$], qb[$];
  pipe_t       pipe[$];
  int          cyc = 0;
  int          pct_s[2], pct_m[2], pct_a, pct_b;
  bit          seq_mode = 0;
  int          seq_val = 0;

  // DUT-side observations.
  int obs_acc[2], obs_ret[2], obs_a, obs_b;
  int acc_log[$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  task automatic applyStimulus();
    for (int k = 0; k < 2; k++) begin
      if (!req_v[k] && ($urandom_range(99) < pct_s[k])) begin
        req_v[k] = 1'b1;
        if (seq_mode) begin
          req_a[k] = 32'(seq_val);
          req_b[k] = 32'(seq_val + 1);
          seq_val++;
        end else begin
          req_a[k] = $urandom;
          req_b[k] = $urandom;
        end
      end
    end
    s0_tvalid = req_v[0]; s0_a_tdata = req_a[0]; s0_b_tdata = req_b[0];
    s1_tvalid = req_v[1]; s1_a_tdata = req_a[1]; s1_b_tdata = req_b[1];
    m0_tready    = ($urandom_range(99) < pct_m[0]);
    m1_tready    = ($urandom_range(99) < pct_m[1]);
    mul_a_tready = ($urandom_range(99) < pct_a);
    mul_b_tready = ($urandom_range(99) < pct_b);
    if (pipe.size() > 0 && pipe[0].rdy <= cyc) begin
      mul_p_tvalid = 1'b1;
      mul_p_tdata  = pipe[0].p;
    end else begin
      mul_p_tvalid = 1'b0;
      mul_p_tdata  = {$urandom, $urandom};
    end
  endtask

  task automatic runCycle();
    bit any_v, g, room, hv, head, mpr;
    exp_t e;
    logic [63:0] x, y;
    applyStimulus();
    #1;
    if (!rst) begin
      m_busy = 0; m_apend = 0; m_bpend = 0; m_count = 0; m_last = 1; m_err = 0;
      exp_q.delete(); qa.delete(); qb.delete();
    end
    any_v = req_v[0] || req_v[1];
    g     = (req_v[0] && req_v[1]) ? !m_last : req_v[1];
    room  = rst && !m_busy && (m_count < MAXO);
    if (any_v) begin
      checkOutput("s0_tready", s0_tready, room && !g);
      checkOutput("s1_tready", s1_tready, room && g);
    end else begin
      checkOutput("tready_exclusive", s0_tready && s1_tready, 0);
    end
    checkOutput("mul_a_tvalid", mul_a_tvalid, m_busy && m_apend);
    checkOutput("mul_b_tvalid", mul_b_tvalid, m_busy && m_bpend);
    if (m_busy && m_apend) checkOutput("mul_a_tdata", mul_a_tdata, m_opa);
    if (m_busy && m_bpend) checkOutput("mul_b_tdata", mul_b_tdata, m_opb);
    if (!rst) begin
      checkOutput("rst_mul_a_tdata", mul_a_tdata, 0);
      checkOutput("rst_mul_b_tdata", mul_b_tdata, 0);
    end
    hv   = mul_p_tvalid && (exp_q.size() > 0);
    head = (exp_q.size() > 0) ? exp_q[0].tag : 1'b0;
    checkOutput("m0_tvalid", m0_tvalid, hv && !head);
    checkOutput("m1_tvalid", m1_tvalid, hv && head);
    if (hv && !head) checkOutput("m0_tdata", m0_tdata, exp_q[0].prod);
    if (hv && head)  checkOutput("m1_tdata", m1_tdata, exp_q[0].prod);
    mpr = rst && ((exp_q.size() == 0) || (head ? m1_tready : m0_tready));
    if (!rst || mul_p_tvalid || exp_q.size() > 0) checkOutput("mul_p_tready", mul_p_tready, mpr);
    checkOutput("err_orphan", err_orphan, m_err);

    // What the DUT actually did this cycle drives the stand-in multiplier.
    if (s0_tvalid && s0_tready) begin obs_acc[0]++; acc_log.push_back(0); end
    if (s1_tvalid && s1_tready) begin obs_acc[1]++; acc_log.push_back(1); end
    if (m0_tvalid && m0_tready) obs_ret[0]++;
    if (m1_tvalid && m1_tready) obs_ret[1]++;
    if (mul_a_tvalid && mul_a_tready) begin obs_a++; qa.push_back(mul_a_tdata); end
    if (mul_b_tvalid && mul_b_tready) begin obs_b++; qb.push_back(mul_b_tdata); end
    if (mul_p_tvalid && mul_p_tready) pipe.delete(0);
    while (qa.size() > 0 && qb.size() > 0) begin
      pipe_t pe;
      x = {32'b0, qa[0]};
      y = {32'b0, qb[0]};
      pe.p = x * y;
      pe.rdy = cyc + LAT;
      pipe.push_back(pe);
      qa.delete(0); qb.delete(0);
    end

    if (rst) begin
      if (mul_p_tvalid && mpr) begin
        if (exp_q.size() > 0) begin exp_q.delete(0); m_count--; end
        else m_err = 1;
      end
      if (m_busy) begin
        if (m_apend && mul_a_tready) m_apend = 0;
        if (m_bpend && mul_b_tready) m_bpend = 0;
        if (!m_apend && !m_bpend) m_busy = 0;
      end else if (any_v && room) begin
        m_busy = 1; m_apend = 1; m_bpend = 1;
        m_opa = req_a[g]; m_opb = req_b[g];
        x = {32'b0, m_opa};
        y = {32'b0, m_opb};
        e.tag  = g;
        e.prod = x * y;
        exp_q.push_back(e);
        m_count++;
        m_last = g;
        req_v[g] = 0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic setKnobs(input int s0, input int s1, input int r0, input int r1, input int ra, input int rb);
    pct_s[0] = s0; pct_s[1] = s1; pct_m[0] = r0; pct_m[1] = r1; pct_a = ra; pct_b = rb;
  endtask

  task automatic clearObs();
    obs_acc[0] = 0; obs_acc[1] = 0; obs_ret[0] = 0; obs_ret[1] = 0; obs_a = 0; obs_b = 0;
    acc_log.delete();
  endtask

  task automatic drainAll(input string tag);
    int n;
    setKnobs(0, 0, 100, 100, 100, 100);
    n = 0;
    while ((exp_q.size() > 0 || m_busy || pipe.size() > 0 || req_v[0] || req_v[1]) && n < 300) begin
      runCycle();
      n++;
    end
    checkOutput(tag, (n < 300), 1);
  endtask

  initial begin
    int viol, n;
    rst = 1'b0;
    req_v[0] = 0; req_v[1] = 0;
    setKnobs(0, 0, 100, 100, 100, 100);
    clearObs();
    @(posedge clk); #1;
    runCycle();
    runCycle();
    rst = 1'b1;
    runCycle();

    // Single requester with known operands.
    clearObs();
    req_v[0] = 1; req_a[0] = 32'd13321234; req_b[0] = 32'd54412351;
    for (int i = 0; i < 15; i++) runCycle();
    checkOutput("s0_only_m0_beats", obs_ret[0], 1);
    checkOutput("s0_only_m1_beats", obs_ret[1], 0);

    // Both requesters always valid: grants must alternate.
    clearObs();
    seq_mode = 1;
    setKnobs(100, 100, 100, 100, 100, 100);
    for (int i = 0; i < 40; i++) runCycle();
    seq_mode = 0;
    viol = 0;
    for (int i = 1; i < acc_log.size(); i++) if (acc_log[i] == acc_log[i-1]) viol++;
    checkOutput("alternation_repeats", viol, 0);
    checkOutput("alternation_some_grants", (acc_log.size() >= 10), 1);
    drainAll("drain_after_alt");
    checkOutput("alt_returns_s0", obs_ret[0], obs_acc[0]);
    checkOutput("alt_returns_s1", obs_ret[1], obs_acc[1]);

    // A stream stalled for three cycles while B completes.
    clearObs();
    setKnobs(0, 0, 100, 100, 0, 100);
    req_v[0] = 1; req_a[0] = $urandom; req_b[0] = $urandom;
    for (int i = 0; i < 4; i++) runCycle();
    checkOutput("astall_a_pending", obs_a, 0);
    checkOutput("astall_b_once", obs_b, 1);
    pct_a = 100;
    for (int i = 0; i < 10; i++) runCycle();
    checkOutput("astall_a_beats", obs_a, 1);
    checkOutput("astall_b_beats", obs_b, 1);
    checkOutput("astall_results", obs_ret[0], 1);

    // Output backpressure fills the tag FIFO; fifth request must wait.
    clearObs();
    setKnobs(100, 0, 0, 100, 100, 100);
    for (int i = 0; i < 25; i++) runCycle();
    checkOutput("full_accepts", obs_acc[0], MAXO);
    checkOutput("full_s0_tready", s0_tready, 0);
    pct_m[0] = 100;
    for (int i = 0; i < 30; i++) runCycle();
    drainAll("drain_after_full");
    checkOutput("full_returns", obs_ret[0], obs_acc[0]);

    // Randomized traffic.
    clearObs();
    for (int ph = 0; ph < 10; ph++) begin
      setKnobs($urandom_range(100), $urandom_range(100), $urandom_range(20, 100),
               $urandom_range(20, 100), $urandom_range(20, 100), $urandom_range(20, 100));
      for (int i = 0; i < 50; i++) runCycle();
    end
    drainAll("drain_after_random");
    checkOutput("random_returns_s0", obs_ret[0], obs_acc[0]);
    checkOutput("random_returns_s1", obs_ret[1], obs_acc[1]);

    // Reset while the second of two ops is being issued.
    setKnobs(100, 0, 0, 100, 100, 100);
    n = 0;
    while (!(m_busy && m_count == 2) && n < 60) begin runCycle(); n++; end
    checkOutput("reach_issue_two_out", (n < 60), 1);
    pct_a = 0; pct_b = 0;
    req_v[0] = 0; req_v[1] = 0;
    setKnobs(0, 0, 100, 100, 0, 0);
    rst = 1'b0;
    runCycle();
    runCycle();
    rst = 1'b1;
    setKnobs(0, 0, 100, 100, 100, 100);
    for (int i = 0; i < 15; i++) runCycle();
    checkOutput("err_orphan_sticky", err_orphan, 1);
    checkOutput("orphans_absorbed", pipe.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
